// File: rtl/bullet_pkg.sv
// Shared defaults and derived widths for the bullet tracker / collision engine.
// No logic; constants and width helpers only.
// No flow control.
package bullet_pkg;

    localparam int N_AST_D  = 8;
    localparam int N_BUL_D  = 4;
    localparam int XW_D     = 8;
    localparam int YW_D     = 7;
    localparam int HALF_W_D = 3;
    localparam int HALF_H_D = 2;
    localparam int STEP_D   = 2;

    // Width of the 1-based asteroid index (0 reserved for "no hit").
    function automatic int aw_of(input int n_ast);
        return $clog2(n_ast + 1);
    endfunction

    // Width of a bullet slot index, never narrower than one bit.
    function automatic int bw_of(input int n_bul);
        return (n_bul > 1) ? $clog2(n_bul) : 1;
    endfunction

endpackage

// File: rtl/bullet_hit_cmp.sv
// Tests one bullet against every asteroid window; lowest-index live asteroid wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is consumed.
module bullet_hit_cmp
    import bullet_pkg::*;
#(
    parameter int N_AST  = N_AST_D,
    parameter int XW     = XW_D,
    parameter int YW     = YW_D,
    parameter int HALF_W = HALF_W_D,
    parameter int HALF_H = HALF_H_D,
    localparam int AW    = aw_of(N_AST)
) (
    input  logic [XW-1:0]       bx,
    input  logic [YW-1:0]       by,
    input  logic [N_AST*XW-1:0] ast_x,
    input  logic [N_AST*YW-1:0] ast_y,
    input  logic [N_AST-1:0]    ast_alive,
    output logic                hit,
    output logic [AW-1:0]       idx
);

    // One extra bit on every operand so adding the half-window never wraps.
    localparam logic [XW:0] HW = (XW+1)'(HALF_W);
    localparam logic [YW:0] HH = (YW+1)'(HALF_H);

    logic [XW:0]      bxe;
    logic [YW:0]      bye;
    logic [N_AST-1:0] match;

    assign bxe = {1'b0, bx};
    assign bye = {1'b0, by};

    for (genvar g = 0; g < N_AST; g++) begin : g_win
        logic [XW:0] ax;
        logic [YW:0] ay;
        assign ax = {1'b0, ast_x[g*XW +: XW]};
        assign ay = {1'b0, ast_y[g*YW +: YW]};
        assign match[g] = ast_alive[g]
                        && (ax + HW >= bxe) && (bxe + HW > ax)
                        && (ay + HH >= bye) && (bye + HH > ay);
    end

    // Priority encode, scanning downward so the lowest matching index is left last.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N_AST - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit = 1'b1;
                idx = AW'(i + 1);
            end
        end
    end

endmodule

// File: rtl/bullet_engine.sv
// Tracks up to N_BUL bullets, moves them on frame ticks, scans one slot per cycle for hits.
// Latency: fire edge -> slot live next cycle; scanned hit -> hit_valid next cycle.
// Backpressure: a hit found while the output is full stalls the scan pointer; the slot keeps moving.
module bullet_engine
    import bullet_pkg::*;
#(
    parameter int N_AST  = N_AST_D,
    parameter int N_BUL  = N_BUL_D,
    parameter int XW     = XW_D,
    parameter int YW     = YW_D,
    parameter int HALF_W = HALF_W_D,
    parameter int HALF_H = HALF_H_D,
    parameter int STEP   = STEP_D,
    localparam int AW    = aw_of(N_AST),
    localparam int BW    = bw_of(N_BUL)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                fire,
    input  logic                tick,
    input  logic [XW-1:0]       ss_x,
    input  logic [YW-1:0]       ss_y,
    input  logic [N_AST*XW-1:0] ast_x,
    input  logic [N_AST*YW-1:0] ast_y,
    input  logic [N_AST-1:0]    ast_alive,
    output logic [N_BUL-1:0]    bul_active,
    output logic [N_BUL*XW-1:0] bul_x,
    output logic [N_BUL*YW-1:0] bul_y,
    output logic                fire_drop,
    output logic                hit_valid,
    input  logic                hit_ready,
    output logic [AW-1:0]       hit_ast,
    output logic [BW-1:0]       hit_bul
);

    localparam logic [YW-1:0] STEP_Y = YW'(STEP);

    logic [N_BUL-1:0] act;
    logic [XW-1:0]    bx [N_BUL];
    logic [YW-1:0]    by [N_BUL];
    logic             fire_q;
    logic [BW-1:0]    sp;
    logic [BW-1:0]    sp_nxt;
    logic             fire_edge;
    logic             alloc_ok;
    logic [BW-1:0]    alloc_idx;
    logic             cmp_hit;
    logic [AW-1:0]    cmp_idx;
    logic             scan_hit;
    logic             capture;
    logic             stall;

    assign bul_active = act;

    for (genvar g = 0; g < N_BUL; g++) begin : g_pack
        assign bul_x[g*XW +: XW] = bx[g];
        assign bul_y[g*YW +: YW] = by[g];
    end

    bullet_hit_cmp #(
        .N_AST  (N_AST),
        .XW     (XW),
        .YW     (YW),
        .HALF_W (HALF_W),
        .HALF_H (HALF_H)
    ) u_cmp (
        .bx        (bx[sp]),
        .by        (by[sp]),
        .ast_x     (ast_x),
        .ast_y     (ast_y),
        .ast_alive (ast_alive),
        .hit       (cmp_hit),
        .idx       (cmp_idx)
    );

    assign fire_edge = fire & ~fire_q;
    assign scan_hit  = act[sp] & cmp_hit;
    assign capture   = scan_hit & (~hit_valid | hit_ready);
    assign stall     = scan_hit & hit_valid & ~hit_ready;

    // Lowest free slot, judged on occupancy at the start of the cycle only.
    always_comb begin
        alloc_ok  = 1'b0;
        alloc_idx = '0;
        for (int j = N_BUL - 1; j >= 0; j--) begin
            if (!act[j]) begin
                alloc_ok  = 1'b1;
                alloc_idx = BW'(j);
            end
        end
    end

    // Scan pointer advances every cycle unless a found hit is waiting for the output.
    always_comb begin
        sp_nxt = sp;
        if (!stall) begin
            sp_nxt = (sp == BW'(N_BUL - 1)) ? '0 : sp + BW'(1);
        end
    end

    // Slot state: allocation beats capture beats movement; a hit slot is not moved.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            act <= '0;
            for (int j = 0; j < N_BUL; j++) begin
                bx[j] <= '0;
                by[j] <= '0;
            end
        end else begin
            for (int j = 0; j < N_BUL; j++) begin
                if (fire_edge && alloc_ok && alloc_idx == BW'(j)) begin
                    act[j] <= 1'b1;
                    bx[j]  <= ss_x;
                    by[j]  <= ss_y;
                end else if (capture && sp == BW'(j)) begin
                    act[j] <= 1'b0;
                end else if (tick && act[j]) begin
                    if (by[j] < STEP_Y) begin
                        act[j] <= 1'b0;
                    end else begin
                        by[j] <= by[j] - STEP_Y;
                    end
                end
            end
        end
    end

    // Fire edge detector, drop pulse, scan pointer and the hit output register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fire_q    <= 1'b0;
            fire_drop <= 1'b0;
            sp        <= '0;
            hit_valid <= 1'b0;
            hit_ast   <= '0;
            hit_bul   <= '0;
        end else begin
            fire_q    <= fire;
            fire_drop <= fire_edge & ~alloc_ok;
            sp        <= sp_nxt;
            if (capture) begin
                hit_valid <= 1'b1;
                hit_ast   <= cmp_idx;
                hit_bul   <= sp;
            end else if (hit_ready) begin
                hit_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bullet_engine.sv
module tb_bullet_engine;

    localparam int N_AST = 8;
    localparam int N_BUL = 4;
    localparam int XW    = 8;
    localparam int YW    = 7;
    localparam int AW    = 4;
    localparam int BW    = 2;

    logic                clk = 1'b0;
    logic                resetn;
    logic                fire;
    logic                tick;
    logic [XW-1:0]       ss_x;
    logic [YW-1:0]       ss_y;
    logic [N_AST*XW-1:0] ast_x;
    logic [N_AST*YW-1:0] ast_y;
    logic [N_AST-1:0]    ast_alive;
    logic [N_BUL-1:0]    bul_active;
    logic [N_BUL*XW-1:0] bul_x;
    logic [N_BUL*YW-1:0] bul_y;
    logic                fire_drop;
    logic                hit_valid;
    logic                hit_ready;
    logic [AW-1:0]       hit_ast;
    logic [BW-1:0]       hit_bul;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [BW-1:0] b;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    bullet_engine dut (
        .clk        (clk),
        .resetn     (resetn),
        .fire       (fire),
        .tick       (tick),
        .ss_x       (ss_x),
        .ss_y       (ss_y),
        .ast_x      (ast_x),
        .ast_y      (ast_y),
        .ast_alive  (ast_alive),
        .bul_active (bul_active),
        .bul_x      (bul_x),
        .bul_y      (bul_y),
        .fire_drop  (fire_drop),
        .hit_valid  (hit_valid),
        .hit_ready  (hit_ready),
        .hit_ast    (hit_ast),
        .hit_bul    (hit_bul)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_chk++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, req, $time);
        end
    endtask

    // Scoreboard monitor: inputs change just after posedge, so at negedge valid&ready
    // describes the handshake the next posedge will complete.
    always @(negedge clk) begin
        ev_t e;
        if (resetn && hit_valid && hit_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_hit: got ast=%0d bul=%0d, expected no event", hit_ast, hit_bul);
            end else begin
                e = exp_q.pop_front();
                check("hit_ast", hit_ast, e.a);
                check("hit_bul", hit_bul, e.b);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) nxt();
    endtask

    task automatic set_ast(input int i, input int x, input int y, input logic alive);
        ast_x[i*XW +: XW] = XW'(x);
        ast_y[i*YW +: YW] = YW'(y);
        ast_alive[i]      = alive;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        fire      = 1'b0;
        tick      = 1'b0;
        hit_ready = 1'b1;
        ss_x      = '0;
        ss_y      = '0;
        ast_x     = '0;
        ast_y     = '0;
        ast_alive = '0;
        #1;
        check("rst_active", bul_active, 0);
        check("rst_valid", hit_valid, 0);
        check("rst_drop", fire_drop, 0);
        nxt();
        resetn = 1'b1;
    endtask

    task automatic fire_at(input int x, input int y);
        ss_x = XW'(x);
        ss_y = YW'(y);
        fire = 1'b1;
        nxt();
        fire = 1'b0;
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!hit_valid && k < 20) begin
            nxt();
            k++;
        end
        check("hit_valid_seen", hit_valid, 1);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            nxt();
            k++;
        end
        nxt();
        check("events_drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200us");
        $fatal(1, "timeout");
    end

    initial begin
        // Basic fire: slot 0 then slot 1 with spawn positions.
        do_reset();
        fire_at(40, 100);
        check("f1_active", bul_active, 4'b0001);
        check("f1_x", bul_x[0 +: XW], 40);
        check("f1_y", bul_y[0 +: YW], 100);
        nxt();
        fire_at(50, 90);
        check("f2_active", bul_active, 4'b0011);
        check("f2_x", bul_x[XW +: XW], 50);
        check("f2_y", bul_y[YW +: YW], 90);

        // N_BUL+1 edges: the last one finds no slot and pulses fire_drop once.
        do_reset();
        for (int k = 0; k < N_BUL + 1; k++) begin
            fire_at(10 + k, 20);
            if (k < N_BUL) begin
                check("fill_drop", fire_drop, 0);
                check("fill_active", bul_active, (1 << (k + 1)) - 1);
            end else begin
                check("full_drop", fire_drop, 1);
                check("full_active", bul_active, 4'b1111);
            end
            nxt();
        end
        check("drop_one_cycle", fire_drop, 0);

        // Fire held high allocates once.
        do_reset();
        fire = 1'b1;
        cycles(3);
        fire = 1'b0;
        check("held_fire", bul_active, 4'b0001);

        // Movement: y 10 -> 8,6,4,2,0 then off-screen since 0 < STEP.
        do_reset();
        fire_at(40, 10);
        for (int k = 1; k <= 5; k++) begin
            tick = 1'b1;
            nxt();
            tick = 1'b0;
            check("move_active", bul_active[0], 1);
            check("move_y", bul_y[0 +: YW], 10 - 2 * k);
        end
        tick = 1'b1;
        nxt();
        tick = 1'b0;
        check("offscreen", bul_active, 0);

        // Two asteroids in the same window: the lower index (2 -> 3) wins.
        do_reset();
        set_ast(2, 41, 50, 1'b1);
        set_ast(5, 41, 50, 1'b1);
        exp_q.push_back('{a: 4'd3, b: 2'd0});
        fire_at(40, 50);
        check("prio_spawn", bul_active, 4'b0001);
        wait_drain();
        check("prio_cleared", bul_active, 0);
        check("prio_valid_drop", hit_valid, 0);

        // Back-pressure: first event held, second slot waits, then follows.
        do_reset();
        hit_ready = 1'b0;
        set_ast(0, 100, 60, 1'b0);
        fire_at(100, 60);
        nxt();
        fire_at(100, 60);
        set_ast(0, 100, 60, 1'b1);
        exp_q.push_back('{a: 4'd1, b: 2'd0});
        exp_q.push_back('{a: 4'd1, b: 2'd1});
        wait_valid();
        for (int k = 0; k < 6; k++) begin
            nxt();
            check("stall_valid", hit_valid, 1);
            check("stall_ast", hit_ast, 1);
            check("stall_bul", hit_bul, 0);
            check("stall_active", bul_active, 4'b0010);
        end
        hit_ready = 1'b1;
        nxt();
        check("b2b_valid", hit_valid, 1);
        check("b2b_bul", hit_bul, 1);
        check("b2b_active", bul_active, 0);
        nxt();
        check("b2b_done", hit_valid, 0);
        wait_drain();

        // No wrap at the left edge: x=254 vs asteroid at x=1 misses.
        do_reset();
        set_ast(0, 1, 60, 1'b1);
        fire_at(254, 60);
        cycles(8);
        check("nowrap_valid", hit_valid, 0);
        check("nowrap_active", bul_active, 4'b0001);

        // x=0 vs asteroid at x=1 hits.
        do_reset();
        set_ast(0, 1, 60, 1'b1);
        exp_q.push_back('{a: 4'd1, b: 2'd0});
        fire_at(0, 60);
        wait_drain();
        check("edge_hit_cleared", bul_active, 0);

        // Reset while an event is pending clears it at once.
        do_reset();
        hit_ready = 1'b0;
        set_ast(0, 30, 30, 1'b1);
        fire_at(30, 30);
        wait_valid();
        resetn = 1'b0;
        #1;
        check("midrst_valid", hit_valid, 0);
        check("midrst_ast", hit_ast, 0);
        check("midrst_active", bul_active, 0);
        do_reset();

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
